debounce_scan_ctrl: RTL and testbench
=====================================

# debounce_scan_ctrl

Time-multiplexed debounce controller and event scheduler for a bank of raw push-button inputs. One scan engine visits the channels in round-robin order at a programmable rate and tracks a short sample history per channel. When a channel's history agrees on a new level, the controller updates that channel's stable output and queues a press/release event. Downstream logic (display, counters, FSMs) consumes the events through a valid/ready FIFO interface, in place of one free-running debounce instance per button.

## Interface
- N, 4, number of input channels (2..16)
- SAMPLES, 3, consecutive equal samples required to accept a level (2..8)
- DIV, 4, clk cycles per scan step (>=1)
- FIFO_DEPTH, 4, event queue depth (power of two, >=2)

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous active-high reset
- in  input  N  raw, asynchronous, bouncy button levels
- enable  input  1  scan enable; low freezes scanning
- stable  output  N  debounced level per channel
- ev_valid  output  1  event queue non-empty
- ev_ready  input  1  consumer accepts head event
- ev_chan  output  clog2(N)  channel index of head event
- ev_press  output  1  1 = rising (press), 0 = falling (release)
- overflow  output  1  sticky: an event was dropped

## Operation
- Synchronizer: each `in` bit passes through 2 flops. Only synchronized bits are sampled.
- Prescaler `div_cnt` (0..DIV-1):
  - Increments on every clock while enable=1.
  - At DIV-1 it asserts an internal `tick` for that cycle and wraps to 0.
- Scan pointer `ptr` (0..N-1):
  - Advances by 1 at each tick edge.
  - Wraps from N-1 to 0.
- On a tick, for channel ptr:
  - Shift the synchronized bit into `hist[ptr]` (SAMPLES bits, newest in LSB).
  - If the shifted history is all ones and stable[ptr]=0, set stable[ptr]=1 and push event {ptr,1}.
  - If the shifted history is all zeros and stable[ptr]=1, clear stable[ptr] and push event {ptr,0}.
  - Otherwise no change.
- At most one event is pushed per tick.
- Event FIFO:
  - First-word fall-through.
  - ev_valid = not empty; ev_chan and ev_press show the head entry.
  - Pop occurs when ev_valid && ev_ready.
- Full FIFO:
  - A push with no simultaneous pop is dropped and sets overflow=1.
  - stable is updated regardless of the drop.
  - A push on a full FIFO with a same-cycle pop is accepted; occupancy is unchanged.
- overflow clears only on rst.
- enable=0:
  - div_cnt, ptr, hist and stable hold.
  - No ticks occur.
  - The FIFO continues to drain.
  - The synchronizer keeps running.
- Reset (asynchronous, at any time including mid-scan or with the FIFO non-empty):
  - stable=0, hist=all 0, ptr=0, div_cnt=0.
  - FIFO empty, so ev_valid=0.
  - overflow=0; synchronizer flops=0.
  - ev_chan=0, ev_press=0.

## Timing
- First tick occurs in cycle DIV-1 after rst deassertion with enable=1. It processes channel 0.
- Each channel is visited every N*DIV cycles.
- Press latency from a clean input edge to stable:
  - 2 cycles of synchronizer, plus
  - up to SAMPLES visits, i.e. at most 2 + SAMPLES*N*DIV + DIV cycles.
- stable and the FIFO push update on the tick edge. ev_valid rises the cycle after that edge when the FIFO was empty.
- A pop takes effect on the edge where ev_valid && ev_ready. The next entry, or ev_valid=0, is visible right after that edge.
- Events leave in push order.
- A level held for fewer than (SAMPLES-1)*N*DIV cycles never produces an event.

## Test plan
All scenarios use defaults (N=4, SAMPLES=3, DIV=4; 16-cycle visit interval).

- Reset values: assert rst mid-scan with 2 events queued.
  - Immediately, without waiting for a clock edge: stable=0000, ev_valid=0, overflow=0.
  - After release, first tick at cycle 3 on channel 0.
- Clean press: in[0]=1 held from cycle 0, ev_ready=1.
  - stable[0] rises on the third channel-0 visit.
  - Exactly one event {chan=0, press=1}, popped one cycle after ev_valid rises.
  - Releasing in[0] later yields {chan=0, press=0}.
- Bounce rejection: in[1] pulses to 1 for 20 cycles, up to 3 times with 20 cycles low between pulses.
  - No event; stable[1]=0 throughout.
- Backpressure/overflow: ev_ready=0; produce 5 state changes across channels 0..3.
  - FIFO holds the first 4 in order; overflow=1.
  - stable reflects all 5 changes.
  - Raising ev_ready drains 4 events oldest-first, one per cycle, then ev_valid=0.
- Full push+pop: with the FIFO full, align ev_ready=1 with a tick that pushes.
  - The push is accepted and occupancy stays 4.
  - overflow is not set by this push.
- Enable freeze: drop enable mid-history, hold 100 cycles, change in, restore.
  - ptr, hist and stable are unchanged during the freeze.
  - Queued events still drain.
  - Scanning resumes from the same ptr.

Source files
------------

// File: rtl/debounce_scan_ctrl.sv
// Time-multiplexed button debouncer: one scan engine walks the channels at a
// prescaled rate, keeps a short sample history per channel and queues edge events.
module debounce_scan_ctrl #(
  parameter int N          = 4,
  parameter int SAMPLES    = 3,
  parameter int DIV        = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in,
  input  logic                 enable,
  output logic [N-1:0]         stable,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [$clog2(N)-1:0] ev_chan,
  output logic                 ev_press,
  output logic                 overflow
);

  localparam int CW = $clog2(N);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = CW + 1;

  function automatic logic all_ones(input logic [SAMPLES-1:0] h);
    return &h;
  endfunction

  function automatic logic all_zeros(input logic [SAMPLES-1:0] h);
    return ~|h;
  endfunction

  logic [N-1:0]         sync1_r, sync2_r;
  logic [DW-1:0]        div_cnt_r;
  logic [CW-1:0]        ptr_r;
  logic [SAMPLES-1:0]   hist_r [N];
  logic [N-1:0]         stable_r;
  logic                 tick_s;
  logic [SAMPLES-1:0]   hist_new_s;
  logic                 push_req_s;
  logic [EW-1:0]        push_data_s;

  logic [EW-1:0]        mem_r [FIFO_DEPTH];
  logic [AW-1:0]        rd_r, wr_r;
  logic [AW:0]          cnt_r, cnt_nxt_s;
  logic                 ev_valid_r, overflow_r;
  logic [CW-1:0]        ev_chan_r;
  logic                 ev_press_r;
  logic [EW-1:0]        head_nxt_s;
  logic                 full_s, pop_s, push_ok_s, drop_s;

  // Two-flop synchronizer on every raw input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= in;
      sync2_r <= sync1_r;
    end
  end

  assign tick_s = enable && (div_cnt_r == DW'(DIV - 1));

  // Shifted history of the visited channel and the resulting event request
  always_comb begin
    hist_new_s  = {hist_r[ptr_r][SAMPLES-2:0], sync2_r[ptr_r]};
    push_req_s  = 1'b0;
    push_data_s = '0;
    if (tick_s && all_ones(hist_new_s) && !stable_r[ptr_r]) begin
      push_req_s  = 1'b1;
      push_data_s = {ptr_r, 1'b1};
    end else if (tick_s && all_zeros(hist_new_s) && stable_r[ptr_r]) begin
      push_req_s  = 1'b1;
      push_data_s = {ptr_r, 1'b0};
    end else begin
      push_req_s  = 1'b0;
      push_data_s = '0;
    end
  end

  // Prescaler, scan pointer, history and debounced levels; all frozen while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= '0;
      ptr_r     <= '0;
      stable_r  <= '0;
      for (int i = 0; i < N; i++) hist_r[i] <= '0;
    end else if (enable) begin
      div_cnt_r <= tick_s ? '0 : div_cnt_r + DW'(1);
      if (tick_s) begin
        hist_r[ptr_r] <= hist_new_s;
        if (push_req_s) stable_r[ptr_r] <= push_data_s[0];
        ptr_r <= (ptr_r == CW'(N - 1)) ? '0 : ptr_r + CW'(1);
      end
    end
  end

  assign full_s    = (cnt_r == (AW+1)'(FIFO_DEPTH));
  assign pop_s     = ev_valid_r && ev_ready;
  assign push_ok_s = push_req_s && (!full_s || pop_s);
  assign drop_s    = push_req_s && full_s && !pop_s;

  // Next occupancy and next head entry, so the head outputs can be registered
  always_comb begin
    cnt_nxt_s  = cnt_r;
    head_nxt_s = {ev_chan_r, ev_press_r};
    case ({push_ok_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + (AW+1)'(1);
      2'b01:   cnt_nxt_s = cnt_r - (AW+1)'(1);
      default: cnt_nxt_s = cnt_r;
    endcase
    if (pop_s) begin
      if (cnt_r == (AW+1)'(1)) begin
        head_nxt_s = push_ok_s ? push_data_s : '0;
      end else begin
        head_nxt_s = mem_r[rd_r + AW'(1)];
      end
    end else if ((cnt_r == '0) && push_ok_s) begin
      head_nxt_s = push_data_s;
    end else begin
      head_nxt_s = {ev_chan_r, ev_press_r};
    end
  end

  // Event FIFO storage, pointers, registered head view and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_r       <= '0;
      wr_r       <= '0;
      cnt_r      <= '0;
      ev_valid_r <= 1'b0;
      ev_chan_r  <= '0;
      ev_press_r <= 1'b0;
      overflow_r <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_r] <= push_data_s;
        wr_r        <= wr_r + AW'(1);
      end
      if (pop_s) rd_r <= rd_r + AW'(1);
      if (drop_s) overflow_r <= 1'b1;
      cnt_r      <= cnt_nxt_s;
      ev_valid_r <= (cnt_nxt_s != '0);
      ev_chan_r  <= head_nxt_s[EW-1:1];
      ev_press_r <= head_nxt_s[0];
    end
  end

  assign stable   = stable_r;
  assign ev_valid = ev_valid_r;
  assign ev_chan  = ev_chan_r;
  assign ev_press = ev_press_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Directed bench for debounce_scan_ctrl with an event scoreboard queue.
module tb_debounce_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in;
  logic       enable;
  logic [3:0] stable;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_chan;
  logic       ev_press;
  logic       overflow;

  int         n_cmp = 0;
  int         n_err = 0;
  int         edges = 0;
  logic [2:0] exp_q [$];
  logic [2:0] exp_e;

  debounce_scan_ctrl #(.N(4), .SAMPLES(3), .DIV(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in(in), .enable(enable), .stable(stable),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_chan(ev_chan),
    .ev_press(ev_press), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // edges = number of rising edges since reset was released
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // return 1 time unit after rising edge k (0-based) following reset release
  task automatic wait_edge(input int k);
    int guard;
    guard = 0;
    while (edges < k + 1 && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  // Scoreboard: every handshake must match the oldest expected event
  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL ev_unexpected observed chan=%0d press=%0d expected none", ev_chan, ev_press);
      end
      if (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        check("ev_head", {29'd0, ev_chan, ev_press}, {29'd0, exp_e});
      end
    end
  end

  initial begin
    in = 4'b0000; enable = 1'b1; ev_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stable", stable, 4'b0000);
    check("rst_valid", ev_valid, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_chan", ev_chan, 2'd0);
    check("rst_press", ev_press, 1'b0);

    // clean press and release on channel 0
    in = 4'b0001; ev_ready = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_q.push_back({2'd0, 1'b1});
    wait_edge(34); check("press_early", stable, 4'b0000);
    wait_edge(35); check("press_stable", stable, 4'b0001);
    check("press_valid", ev_valid, 1'b1);
    check("press_chan", ev_chan, 2'd0);
    check("press_dir", ev_press, 1'b1);
    wait_edge(36); check("press_popped", ev_valid, 1'b0);
    wait_edge(39); in = 4'b0000;
    exp_q.push_back({2'd0, 1'b0});
    wait_edge(82); check("rel_early", stable, 4'b0001);
    wait_edge(83); check("rel_stable", stable, 4'b0000);
    check("rel_valid", ev_valid, 1'b1);
    wait_edge(84); check("rel_popped", ev_valid, 1'b0);

    // bounce rejection on channel 1
    for (int p = 0; p < 3; p++) begin
      wait_edge(89 + 40 * p); in[1] = 1'b1;
      wait_edge(109 + 40 * p); in[1] = 1'b0;
      check("bounce_stable", stable[1], 1'b0);
    end
    wait_edge(230); check("bounce_final", stable, 4'b0000);

    // backpressure and overflow
    rst = 1'b1; ev_ready = 1'b0; in = 4'b1111;
    repeat (2) @(negedge clk); rst = 1'b0;
    exp_q.push_back({2'd0, 1'b1}); exp_q.push_back({2'd1, 1'b1});
    exp_q.push_back({2'd2, 1'b1}); exp_q.push_back({2'd3, 1'b1});
    wait_edge(47); check("bp_stable", stable, 4'b1111);
    check("bp_valid", ev_valid, 1'b1);
    wait_edge(48); in = 4'b1110;
    wait_edge(82); check("bp_ovf_early", overflow, 1'b0);
    wait_edge(83); check("bp_ovf", overflow, 1'b1);
    check("bp_stable5", stable, 4'b1110);
    check("bp_head_chan", ev_chan, 2'd0);
    check("bp_head_dir", ev_press, 1'b1);
    wait_edge(90); ev_ready = 1'b1;
    wait_edge(93); check("bp_drain3", ev_valid, 1'b1);
    wait_edge(94); check("bp_drain4", ev_valid, 1'b0);

    // full FIFO with a push aligned to a pop
    rst = 1'b1; ev_ready = 1'b0; in = 4'b1111;
    #1; check("rst_ovf_clear", overflow, 1'b0);
    repeat (2) @(negedge clk); rst = 1'b0;
    exp_q.push_back({2'd0, 1'b1}); exp_q.push_back({2'd1, 1'b1});
    exp_q.push_back({2'd2, 1'b1}); exp_q.push_back({2'd3, 1'b1});
    wait_edge(48); in = 4'b1110;
    exp_q.push_back({2'd0, 1'b0});
    wait_edge(82); ev_ready = 1'b1;
    wait_edge(83); ev_ready = 1'b0;
    check("pp_ovf", overflow, 1'b0);
    check("pp_valid", ev_valid, 1'b1);
    check("pp_head_chan", ev_chan, 2'd1);
    check("pp_stable", stable, 4'b1110);
    wait_edge(90); ev_ready = 1'b1;
    wait_edge(93); check("pp_drain3", ev_valid, 1'b1);
    wait_edge(94); check("pp_drain4", ev_valid, 1'b0);

    // asynchronous reset mid-scan with two events queued
    rst = 1'b1; ev_ready = 1'b0; in = 4'b0011;
    repeat (2) @(negedge clk); rst = 1'b0;
    wait_edge(41); check("mid_valid", ev_valid, 1'b1);
    #1; rst = 1'b1; #1;
    check("mid_rst_stable", stable, 4'b0000);
    check("mid_rst_valid", ev_valid, 1'b0);
    check("mid_rst_ovf", overflow, 1'b0);
    check("mid_rst_chan", ev_chan, 2'd0);
    repeat (2) @(negedge clk); rst = 1'b0;
    exp_q.push_back({2'd0, 1'b1}); exp_q.push_back({2'd1, 1'b1});
    wait_edge(34); check("first_tick_early", stable, 4'b0000);
    wait_edge(35); check("first_tick_ch0", stable, 4'b0001);
    wait_edge(39); check("first_tick_ch1", stable, 4'b0011);

    // enable freeze in the middle of channel 2's history
    wait_edge(40); in = 4'b0111;
    wait_edge(60); enable = 1'b0;
    wait_edge(70); ev_ready = 1'b1;
    wait_edge(72); check("frz_drained", ev_valid, 1'b0);
    check("frz_stable", stable, 4'b0011);
    wait_edge(80); in = 4'b1010;
    wait_edge(150); in = 4'b0111;
    wait_edge(160); check("frz_hold", stable, 4'b0011);
    enable = 1'b1;
    exp_q.push_back({2'd2, 1'b1});
    wait_edge(174); check("resume_early", stable, 4'b0011);
    wait_edge(175); check("resume_ch2", stable, 4'b0111);
    wait_edge(176); check("resume_popped", ev_valid, 1'b0);

    wait_edge(190);
    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
